inout_bus_arbiter: RTL and testbench

INOUT_BUS_ARBITER -- requirements
Module: inout_bus_arbiter

---
 rtl/inout_arb_pkg.sv | 31 +++
 rtl/rr_pick.sv | 32 +++
 rtl/inout_bus_arbiter.sv | 156 +++++++++++++++
 tb/tb_inout_bus_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/inout_arb_pkg.sv
// Shared types and the round-robin selection helper for inout_bus_arbiter.
package inout_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    OWN  = 2'd2
  } arbState_e;

  localparam int unsigned MaxReq = 8;

  // Returns {valid, index}: first set bit of reqVec scanning from (last+1) mod n, wrapping.
  function automatic logic [3:0] rrNext(input logic [MaxReq-1:0] reqVec,
                                        input logic [2:0]        last,
                                        input int unsigned       n);
    logic [3:0]  res;
    int unsigned idx;
    res = '0;
    // Scan farthest candidate first so the nearest one overwrites it.
    for (int unsigned k = MaxReq; k >= 1; k--) begin
      if (k <= n) begin
        idx = (k + {29'd0, last}) % n;
        if (reqVec[idx[2:0]]) begin
          res = {1'b1, idx[2:0]};
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: next requester after 'last', plus a valid flag.
module rr_pick
  import inout_arb_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [$clog2(N)-1:0] next,
  output logic                 valid
);

  localparam int unsigned IdxW = $clog2(N);

  logic [MaxReq-1:0] reqExt;
  logic [2:0]        lastExt;
  logic [3:0]        res;
  logic              unusedBits;

  always_comb begin
    reqExt            = '0;
    reqExt[N-1:0]     = req;
    lastExt           = '0;
    lastExt[IdxW-1:0] = last;
    res               = rrNext(reqExt, lastExt, N);
  end

  assign next       = res[IdxW-1:0];
  assign valid      = res[3];
  assign unusedBits = ^res[2:0];

endmodule

// File: rtl/inout_bus_arbiter.sv
// Shared tristate bus arbiter: round-robin grants with a one-cycle turnaround between
// owners. Define INOUT_BUS_ARB_TIMEOUT_EN to limit each grant to MAX_HOLD cycles.
module inout_bus_arbiter
  import inout_arb_pkg::*;
#(
  parameter int unsigned N        = 2,
  parameter int unsigned W        = 2,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   wr,
  input  logic [N*W-1:0] wdata,
  output logic [N-1:0]   gnt,
  inout  wire  [W-1:0]   bus,
  output logic [W-1:0]   rdata,
  output logic           rvalid,
  output logic           busy
);

  localparam int unsigned IdxW = $clog2(N);

  arbState_e       stateQ, stateD;
  logic [IdxW-1:0] ownerQ, ownerD;
  logic [IdxW-1:0] pickIdx;
  logic            pickValid;
  logic            dirQ, dirD;
  logic            sameQ, sameD;
  logic            armedQ;
  logic [N-1:0]    gntD;
  logic [W-1:0]    ownData;
  logic            ownWr, ownReq;
  logic            driveEn, sampleEn, holdExpire;

  rr_pick #(
    .N(N)
  ) uPick (
    .req  (req),
    .last (ownerQ),
    .next (pickIdx),
    .valid(pickValid)
  );

  always_comb begin
    ownData = '0;
    ownWr   = 1'b0;
    ownReq  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (ownerQ == IdxW'(i)) begin
        ownData = wdata[i*W +: W];
        ownWr   = wr[i];
        ownReq  = req[i];
      end
    end
  end

  // Direction is latched at grant; a mismatch disables both drive and sampling.
  assign driveEn  = (stateQ == OWN) && ownWr && dirQ;
  assign sampleEn = (stateQ == OWN) && !ownWr && !dirQ;
  assign bus      = driveEn ? ownData : {W{1'bz}};
  assign busy     = (stateQ != IDLE);

`ifdef INOUT_BUS_ARB_TIMEOUT_EN
  logic [7:0] holdQ, holdD;

  assign holdExpire = (stateQ == OWN) && (holdQ == 8'(MAX_HOLD - 1));

  always_comb begin
    holdD = holdQ;
    if (stateQ != OWN) begin
      holdD = '0;
    end else if (!holdExpire) begin
      holdD = holdQ + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      holdQ <= '0;
    end else begin
      holdQ <= holdD;
    end
  end
`else
  localparam int unsigned unusedMaxHold = MAX_HOLD;
  assign holdExpire = 1'b0;
`endif

  always_comb begin
    stateD = stateQ;
    ownerD = ownerQ;
    dirD   = dirQ;
    sameD  = sameQ;
    case (stateQ)
      IDLE: begin
        if (armedQ && (|req)) begin
          stateD = TURN;
        end
      end
      TURN: begin
        sameD = 1'b0;
        if (sameQ && ownReq) begin
          stateD = OWN;
          dirD   = ownWr;
        end else if (pickValid) begin
          stateD = OWN;
          ownerD = pickIdx;
          dirD   = wr[pickIdx];
        end else begin
          stateD = IDLE;
        end
      end
      OWN: begin
        if (!ownReq || holdExpire) begin
          stateD = TURN;
        end else if (ownWr != dirQ) begin
          stateD = TURN;
          sameD  = 1'b1;
        end
      end
      default: stateD = IDLE;
    endcase

    gntD = '0;
    if (stateD == OWN) begin
      gntD[ownerD] = 1'b1;
    end
  end

  // armedQ spends the first edge after reset idle, so grants start at the third edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= IDLE;
      ownerQ <= IdxW'(N - 1);
      dirQ   <= 1'b0;
      sameQ  <= 1'b0;
      armedQ <= 1'b0;
      gnt    <= '0;
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      stateQ <= stateD;
      ownerQ <= ownerD;
      dirQ   <= dirD;
      sameQ  <= sameD;
      armedQ <= 1'b1;
      gnt    <= gntD;
      rvalid <= sampleEn;
      if (sampleEn) begin
        rdata <= bus;
      end
    end
  end

endmodule

// File: tb/tb_inout_bus_arbiter.sv
// Self-checking bench for inout_bus_arbiter: directed vector table, timeout pattern,
// async reset mid-grant and a randomized run against a behavioural scheduler model.
module tb_inout_bus_arbiter;

  localparam int unsigned N       = 2;
  localparam int unsigned W       = 2;
  localparam int unsigned MaxHold = 4;
`ifdef INOUT_BUS_ARB_TIMEOUT_EN
  localparam bit TimeoutOn = 1'b1;
`else
  localparam bit TimeoutOn = 1'b0;
`endif
  // The pullups make an undriven bus read as all ones.
  localparam logic [W-1:0] HiZ = 2'b11;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   req   = '0;
  logic [N-1:0]   wr    = '0;
  logic [N*W-1:0] wdata = '0;
  logic [W-1:0]   tbBus = '0;
  logic [N-1:0]   gnt;
  wire  [W-1:0]   bus;
  logic [W-1:0]   rdata;
  logic           rvalid;
  logic           busy;

  // The bench plays the external device answering a read grant.
  wire tbDriveEn = |(gnt & ~wr);
  assign bus = tbDriveEn ? tbBus : {W{1'bz}};
  pullup (bus[0]);
  pullup (bus[1]);

  inout_bus_arbiter #(
    .N       (N),
    .W       (W),
    .MAX_HOLD(MaxHold)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .wr    (wr),
    .wdata (wdata),
    .gnt   (gnt),
    .bus   (bus),
    .rdata (rdata),
    .rvalid(rvalid),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Every-cycle safety: one-hot-or-zero grant; bus floats unless someone may drive it.
  task automatic invChk(input string tag);
    chk({tag, " gnt onehot0"}, {7'd0, $onehot0(gnt)}, 8'd1);
    if (((gnt & wr) == '0) && !tbDriveEn) begin
      chk({tag, " bus released"}, {6'd0, bus}, {6'd0, HiZ});
    end
  endtask

  typedef struct packed {
    logic [1:0] req;
    logic [1:0] wr;
    logic [3:0] wd;
    logic [1:0] tbv;
    logic [1:0] gnt;
    logic       busy;
    logic [1:0] bus;
    logic       rv;
    logic [1:0] rd;
  } vec_t;

  vec_t vecs[19];

  // Behavioural scheduler model.
  bit         mSettle, mGap, mSame, mDir, mRvalid;
  int         mOwner, mLast, mHeld;
  logic [1:0] mRdata;

  task automatic mdlReset();
    mSettle = 1; mGap = 0; mSame = 0; mDir = 0; mRvalid = 0;
    mOwner = -1; mLast = N - 1; mHeld = 0; mRdata = '0;
  endtask

  task automatic mdlStep();
    int o;
    int win;
    mRvalid = 0;
    if (mSettle) begin
      mSettle = 0;
    end else if (mOwner >= 0) begin
      o = mOwner;
      if (!wr[o] && !mDir) begin
        mRvalid = 1;
        mRdata  = tbBus;
      end
      if (!req[o] || (TimeoutOn && mHeld == MaxHold)) begin
        mLast = o; mOwner = -1; mGap = 1; mSame = 0;
      end else if (wr[o] != mDir) begin
        mLast = o; mOwner = -1; mGap = 1; mSame = 1;
      end else begin
        mHeld++;
      end
    end else if (mGap) begin
      mGap = 0;
      win  = -1;
      if (mSame && req[mLast]) begin
        win = mLast;
      end else begin
        for (int s = 1; s <= N; s++) begin
          if (win < 0 && req[(mLast + s) % N]) win = (mLast + s) % N;
        end
      end
      mSame = 0;
      if (win >= 0) begin
        mOwner = win; mHeld = 1; mDir = wr[win];
      end
    end else if (req != '0) begin
      mGap = 1;
    end
  endtask

  function automatic logic [1:0] mdlBus();
    if (mOwner >= 0 && wr[mOwner]) return mDir ? wdata[mOwner*W +: W] : HiZ;
    if (mOwner >= 0) return tbBus;
    return HiZ;
  endfunction

  task automatic doReset();
    rst_n = 1'b0;
    req = '0; wr = '0; wdata = '0; tbBus = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    logic [1:0] expG;
    int pos;

    //                req    wr     wd       tbv    gnt    busy  bus    rv    rd
    vecs[0]  = '{2'b01, 2'b01, 4'b0010, 2'b00, 2'b00, 1'b0, HiZ,   1'b0, 2'b00};
    vecs[1]  = '{2'b01, 2'b01, 4'b0010, 2'b00, 2'b00, 1'b1, HiZ,   1'b0, 2'b00};
    vecs[2]  = '{2'b01, 2'b01, 4'b0010, 2'b00, 2'b01, 1'b1, 2'b10, 1'b0, 2'b00};
    vecs[3]  = '{2'b01, 2'b01, 4'b0010, 2'b00, 2'b01, 1'b1, 2'b10, 1'b0, 2'b00};
    vecs[4]  = '{2'b00, 2'b01, 4'b0010, 2'b00, 2'b00, 1'b1, HiZ,   1'b0, 2'b00};
    vecs[5]  = '{2'b00, 2'b01, 4'b0010, 2'b00, 2'b00, 1'b0, HiZ,   1'b0, 2'b00};
    vecs[6]  = '{2'b01, 2'b00, 4'b0000, 2'b01, 2'b00, 1'b1, HiZ,   1'b0, 2'b00};
    vecs[7]  = '{2'b01, 2'b00, 4'b0000, 2'b01, 2'b01, 1'b1, 2'b01, 1'b0, 2'b00};
    vecs[8]  = '{2'b01, 2'b00, 4'b0000, 2'b01, 2'b01, 1'b1, 2'b01, 1'b1, 2'b01};
    vecs[9]  = '{2'b01, 2'b00, 4'b0000, 2'b10, 2'b01, 1'b1, 2'b10, 1'b1, 2'b10};
    vecs[10] = '{2'b01, 2'b01, 4'b0001, 2'b10, 2'b00, 1'b1, HiZ,   1'b0, 2'b10};
    vecs[11] = '{2'b01, 2'b01, 4'b0001, 2'b10, 2'b01, 1'b1, 2'b01, 1'b0, 2'b10};
    vecs[12] = '{2'b01, 2'b00, 4'b0001, 2'b01, 2'b00, 1'b1, HiZ,   1'b0, 2'b10};
    vecs[13] = '{2'b01, 2'b00, 4'b0001, 2'b01, 2'b01, 1'b1, 2'b01, 1'b0, 2'b10};
    vecs[14] = '{2'b01, 2'b00, 4'b0001, 2'b01, 2'b01, 1'b1, 2'b01, 1'b1, 2'b01};
    vecs[15] = '{2'b10, 2'b10, 4'b0100, 2'b00, 2'b00, 1'b1, HiZ,   1'b1, 2'b00};
    vecs[16] = '{2'b10, 2'b10, 4'b0100, 2'b00, 2'b10, 1'b1, 2'b01, 1'b0, 2'b00};
    vecs[17] = '{2'b00, 2'b10, 4'b0100, 2'b00, 2'b00, 1'b1, HiZ,   1'b0, 2'b00};
    vecs[18] = '{2'b00, 2'b10, 4'b0100, 2'b00, 2'b00, 1'b0, HiZ,   1'b0, 2'b00};

    #2;
    rst_n = 1'b0;
    #3;
    chk("reset gnt",    {6'd0, gnt},   8'd0);
    chk("reset busy",   {7'd0, busy},  8'd0);
    chk("reset rvalid", {7'd0, rvalid}, 8'd0);
    chk("reset rdata",  {6'd0, rdata}, 8'd0);
    chk("reset bus",    {6'd0, bus},   {6'd0, HiZ});
    doReset();

    // Directed table: write grant, release, read grant, both direction changes, handover.
    for (int i = 0; i < 19; i++) begin
      req = vecs[i].req; wr = vecs[i].wr; wdata = vecs[i].wd; tbBus = vecs[i].tbv;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d gnt", i),    {6'd0, gnt},    {6'd0, vecs[i].gnt});
      chk($sformatf("vec%0d busy", i),   {7'd0, busy},   {7'd0, vecs[i].busy});
      chk($sformatf("vec%0d bus", i),    {6'd0, bus},    {6'd0, vecs[i].bus});
      chk($sformatf("vec%0d rvalid", i), {7'd0, rvalid}, {7'd0, vecs[i].rv});
      chk($sformatf("vec%0d rdata", i),  {6'd0, rdata},  {6'd0, vecs[i].rd});
      invChk($sformatf("vec%0d", i));
    end

    // Reset mid-OWN while the DUT drives 00: must release without a clock edge.
    doReset();
    req = 2'b01; wr = 2'b00; tbBus = 2'b11; wdata = 4'b0000;
    ok = 0;
    for (int c = 0; c < 12 && !ok; c++) begin
      @(posedge clk);
      #1;
      if (rvalid && rdata == 2'b11) ok = 1;
    end
    chk("arst read setup", {7'd0, ok}, 8'd1);
    wr = 2'b01;
    ok = 0;
    for (int c = 0; c < 12 && !ok; c++) begin
      @(posedge clk);
      #1;
      if (gnt == 2'b01 && bus == 2'b00) ok = 1;
    end
    chk("arst write setup", {7'd0, ok}, 8'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst gnt",    {6'd0, gnt},    8'd0);
    chk("arst bus",    {6'd0, bus},    {6'd0, HiZ});
    chk("arst rdata",  {6'd0, rdata},  8'd0);
    chk("arst rvalid", {7'd0, rvalid}, 8'd0);
    chk("arst busy",   {7'd0, busy},   8'd0);

    // Both requesters held: alternating 4-cycle grants with timeout, else owner 0 forever.
    doReset();
    req = 2'b11; wr = 2'b11; wdata = 4'b0110;
    for (int k = 0; k < 22; k++) begin
      @(posedge clk);
      #1;
      if (k < 2) begin
        expG = 2'b00;
      end else if (TimeoutOn) begin
        pos  = (k - 2) % 5;
        expG = (pos < 4) ? 2'(1 << (((k - 2) / 5) % 2)) : 2'b00;
      end else begin
        expG = 2'b01;
      end
      chk($sformatf("hold k%0d gnt", k), {6'd0, gnt}, {6'd0, expG});
      invChk($sformatf("hold k%0d", k));
    end

    // Randomized traffic against the scheduler model.
    doReset();
    mdlReset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk);
      mdlStep();
      #1;
      expG = (mOwner >= 0) ? 2'(1 << mOwner) : 2'b00;
      chk($sformatf("rnd%0d gnt", cyc),    {6'd0, gnt},    {6'd0, expG});
      chk($sformatf("rnd%0d busy", cyc),   {7'd0, busy},   {7'd0, (mOwner >= 0 || mGap)});
      chk($sformatf("rnd%0d bus", cyc),    {6'd0, bus},    {6'd0, mdlBus()});
      chk($sformatf("rnd%0d rvalid", cyc), {7'd0, rvalid}, {7'd0, mRvalid});
      chk($sformatf("rnd%0d rdata", cyc),  {6'd0, rdata},  {6'd0, mRdata});
      invChk($sformatf("rnd%0d", cyc));
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(5) == 0) req[i] = ~req[i];
        if ($urandom_range(9) == 0) wr[i]  = ~wr[i];
      end
      wdata = 4'($urandom);
      tbBus = 2'($urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
